monster_formation: RTL and testbench

Parametrised controller for a row of N marching monsters in the Space Monsters display path. It replaces the fixed five-monster position registers with a shared formation origin and a per-monster alive mask. A left/right/descend state machine advances the formation on each move strobe, and a kill port removes monsters. It also produces a registered per-pixel hit for the top-level rgb priority mux, alongside the tank renderer.

---
 rtl/mons_pkg.sv | 8 +
 rtl/monster_formation_if.sv | 22 ++
 rtl/mons_edge_finder.sv | 18 +
 rtl/monster_formation.sv | 128 ++++++++++++
 tb/tb_monster_formation.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mons_pkg.sv
// mons_pkg: formation FSM states and display colours shared with the tank renderer
package mons_pkg;
  typedef enum logic [2:0] {MARCH_R, MARCH_L, DESC_R, DESC_L, HALT} state_t;
  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] PURPLE = 3'b101;
endpackage

// File: rtl/monster_formation_if.sv
// monster_formation_if: move/kill/scan inputs and pixel/status outputs of the monster row
interface monster_formation_if #(parameter int N_MONS = 5);
  logic              tick;
  logic [9:0]        hCount;
  logic [9:0]        vCount;
  logic              kill_valid;
  logic [3:0]        kill_idx;
  logic              mons_pixel;
  logic [3:0]        hit_idx;
  logic [N_MONS-1:0] alive;
  logic [4:0]        kill_count;
  logic              all_dead;
  logic              reached_bottom;
  modport master (
    output tick, hCount, vCount, kill_valid, kill_idx,
    input  mons_pixel, hit_idx, alive, kill_count, all_dead, reached_bottom
  );
  modport slave (
    input  tick, hCount, vCount, kill_valid, kill_idx,
    output mons_pixel, hit_idx, alive, kill_count, all_dead, reached_bottom
  );
endinterface

// File: rtl/mons_edge_finder.sv
// mons_edge_finder: lowest and highest live monster index, plus whether any is alive
module mons_edge_finder #(
  parameter int N_MONS = 5
) (
  input  logic [N_MONS-1:0] i_alive,
  output logic [3:0]        o_lo,
  output logic [3:0]        o_hi,
  output logic              o_any
);
  // two priority encoders scanning from opposite ends
  always_comb begin
    o_lo = '0;
    o_hi = '0;
    for (int i = N_MONS - 1; i >= 0; i--) if (i_alive[i]) o_lo = 4'(i);
    for (int i = 0; i < N_MONS; i++) if (i_alive[i]) o_hi = 4'(i);
  end
  assign o_any = |i_alive;
endmodule

// File: rtl/monster_formation.sv
// monster_formation: marching monster row with kills and registered pixel hit; MONS_DESCEND_EN adds descend steps
module monster_formation
  import mons_pkg::*;
#(
  parameter int N_MONS  = 5,
  parameter int SPACING = 100,
  parameter int X_START = 250,
  parameter int Y_START = 100,
  parameter int X_MIN   = 150,
  parameter int X_MAX   = 780,
  parameter int STEP_X  = 2,
  parameter int STEP_Y  = 10,
  parameter int Y_LIMIT = 420,
  parameter int HALF_W  = 5,
  parameter int HALF_H  = 3
) (
  input logic                clk,
  input logic                rst,
  monster_formation_if.slave bus
);
  localparam logic [10:0] SP   = 11'(SPACING);
  localparam logic [10:0] XS   = 11'(X_START);
  localparam logic [10:0] YS   = 11'(Y_START);
  localparam logic [10:0] XMIN = 11'(X_MIN);
  localparam logic [10:0] XMAX = 11'(X_MAX);
  localparam logic [10:0] SX   = 11'(STEP_X);
  localparam logic [10:0] SY   = 11'(STEP_Y);
  localparam logic [10:0] YL   = 11'(Y_LIMIT);
  localparam logic [10:0] HW   = 11'(HALF_W);
  localparam logic [10:0] HH   = 11'(HALF_H);
`ifdef MONS_DESCEND_EN
  localparam state_t AT_R = DESC_R;
  localparam state_t AT_L = DESC_L;
`else
  localparam state_t AT_R = MARCH_L;
  localparam state_t AT_L = MARCH_R;
`endif
  state_t            r_state, w_state;
  logic [10:0]       r_x, r_y, w_x, w_y, w_left, w_right, w_h, w_v;
  logic [N_MONS-1:0] r_alive, w_kill, w_hit;
  logic [15:0]       w_onehot;
  logic [4:0]        r_kill_count;
  logic [3:0]        w_lo, w_hi, w_hit_idx, r_hit_idx;
  logic              w_any, w_bottom, r_bottom, r_all_dead, r_pixel;

  mons_edge_finder #(.N_MONS(N_MONS)) u_edge (
    .i_alive (r_alive),
    .o_lo    (w_lo),
    .o_hi    (w_hi),
    .o_any   (w_any)
  );

  assign w_left   = r_x + {7'd0, w_lo} * SP - HW;
  assign w_right  = r_x + {7'd0, w_hi} * SP + HW;
  assign w_onehot = 16'(1) << bus.kill_idx;
  assign w_kill   = bus.kill_valid ? w_onehot[N_MONS-1:0] & r_alive : '0;
  assign w_h      = {1'b0, bus.hCount};
  assign w_v      = {1'b0, bus.vCount};

  for (genvar k = 0; k < N_MONS; k++) begin : g_mon
    localparam logic [10:0] OFF = 11'(k * SPACING);
    assign w_hit[k] = r_alive[k] && (r_x + OFF - HW <= w_h) && (w_h <= r_x + OFF + HW)
                      && (r_y - HH <= w_v) && (w_v <= r_y + HH);
  end

  // lowest covering index wins the pixel
  always_comb begin
    w_hit_idx = '0;
    for (int i = N_MONS - 1; i >= 0; i--) if (w_hit[i]) w_hit_idx = 4'(i);
  end

  // next position and state; an empty row halts whether or not tick is present
  always_comb begin
    w_state  = r_state;
    w_x      = r_x;
    w_y      = r_y;
    w_bottom = r_bottom;
    if (!w_any) w_state = HALT;
    else if (bus.tick)
      case (r_state)
        MARCH_R: if (w_right + SX > XMAX) w_state = AT_R; else w_x = r_x + SX;
        MARCH_L: if (w_left < XMIN + SX) w_state = AT_L; else w_x = r_x - SX;
`ifdef MONS_DESCEND_EN
        DESC_R, DESC_L: begin
          w_y     = r_y + SY;
          w_state = (r_state == DESC_R) ? MARCH_L : MARCH_R;
          if (r_y + SY + HH >= YL) begin
            w_state  = HALT;
            w_bottom = 1'b1;
          end
        end
`endif
        default: ;
      endcase
  end

  // formation registers, kill bookkeeping and the registered pixel result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MARCH_R;
      r_x          <= XS;
      r_y          <= YS;
      r_alive      <= '1;
      r_kill_count <= '0;
      r_all_dead   <= 1'b0;
      r_bottom     <= 1'b0;
      r_pixel      <= 1'b0;
      r_hit_idx    <= '0;
    end else begin
      r_state      <= w_state;
      r_x          <= w_x;
      r_y          <= w_y;
      r_alive      <= r_alive & ~w_kill;
      r_kill_count <= r_kill_count + 5'(|w_kill);
      r_all_dead   <= r_all_dead | ~w_any;
      r_bottom     <= w_bottom;
      r_pixel      <= |w_hit;
      r_hit_idx    <= w_hit_idx;
    end
  end

  assign bus.mons_pixel     = r_pixel;
  assign bus.hit_idx        = r_hit_idx;
  assign bus.alive          = r_alive;
  assign bus.kill_count     = r_kill_count;
  assign bus.all_dead       = r_all_dead;
  assign bus.reached_bottom = r_bottom;
endmodule

// File: tb/tb_monster_formation.sv
// tb_monster_formation: directed and random play of the monster row against a behavioural model
module tb_monster_formation;
  localparam int N = 5, SP = 100, XS = 250, YS = 100, XMIN = 150, XMAX = 780;
  localparam int SX = 2, SY = 10, YL = 420, HW = 5, HH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  monster_formation_if #(.N_MONS(N)) bus ();
  monster_formation dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int m_x, m_y, m_dir, m_kc, e_idx;
  bit m_desc, m_halt, m_dead, m_bot, e_pix;
  bit [N-1:0] m_alive;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = XS; m_y = YS; m_dir = 1; m_kc = 0;
    m_desc = 0; m_halt = 0; m_dead = 0; m_bot = 0;
    m_alive = '1;
  endtask

  // direction +1/-1 plus a pending-descend flag; edges from the live extent of the row
  task automatic model_advance(input bit t, input bit kv, input int ki);
    bit was_empty;
    int lo, hi;
    was_empty = (m_alive == 0);
    lo = -1; hi = -1;
    for (int i = 0; i < N; i++) if (m_alive[i]) begin if (lo < 0) lo = i; hi = i; end
    if (kv && ki < N) if (m_alive[ki]) begin m_alive[ki] = 0; m_kc++; end
    if (was_empty) begin
      m_halt = 1; m_dead = 1;
    end else if (t && !m_halt) begin
      if (m_desc) begin
        m_y += SY; m_desc = 0; m_dir = -m_dir;
        if (m_y + HH >= YL) begin m_halt = 1; m_bot = 1; end
      end else if (m_dir > 0 ? (m_x + hi * SP + HW + SX > XMAX) : (m_x + lo * SP - HW < XMIN + SX)) begin
`ifdef MONS_DESCEND_EN
        m_desc = 1;
`else
        m_dir = -m_dir;
`endif
      end else m_x += m_dir * SX;
    end
  endtask

  // drive one cycle at the falling edge, advance the model, compare just after the rising edge
  task automatic step(input bit r, input bit t, input int h, input int v, input bit kv, input int ki);
    rst = r;
    bus.tick = t;
    bus.hCount = 10'(h);
    bus.vCount = 10'(v);
    bus.kill_valid = kv;
    bus.kill_idx = 4'(ki);
    e_pix = 0; e_idx = 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_alive[i] && h - (m_x + i * SP) <= HW && (m_x + i * SP) - h <= HW && v - m_y <= HH && m_y - v <= HH) begin
        e_pix = 1; e_idx = i;
      end
    if (r) begin model_reset(); e_pix = 0; e_idx = 0; end
    else model_advance(t, kv, ki);
    @(posedge clk);
    #1;
    chk("mons_pixel", int'(bus.mons_pixel), int'(e_pix));
    chk("hit_idx", int'(bus.hit_idx), e_idx);
    chk("alive", int'(bus.alive), int'(m_alive));
    chk("kill_count", int'(bus.kill_count), m_kc);
    chk("all_dead", int'(bus.all_dead), int'(m_dead));
    chk("reached_bottom", int'(bus.reached_bottom), int'(m_bot));
    @(negedge clk);
  endtask

  initial begin
    int mi, h, v, ex, ey;
    bit r;
    model_reset();
    bus.tick = 0; bus.hCount = 0; bus.vCount = 0; bus.kill_valid = 0; bus.kill_idx = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_alive", int'(bus.alive), 31);
    chk("rst_kill_count", int'(bus.kill_count), 0);
    chk("rst_all_dead", int'(bus.all_dead), 0);
    chk("rst_bottom", int'(bus.reached_bottom), 0);
    chk("rst_pixel", int'(bus.mons_pixel), 0);
    step(0, 1, 250, 100, 0, 0);
    chk("first_pixel", int'(bus.mons_pixel), 1);
    chk("first_idx", int'(bus.hit_idx), 0);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    chk("model_x_after5", m_x, 260);
    step(0, 0, 265, 103, 0, 0);
    chk("corner_pixel", int'(bus.mons_pixel), 1);
    step(0, 0, 266, 100, 0, 0);
    chk("outside_pixel", int'(bus.mons_pixel), 0);
    step(0, 0, 360, 97, 0, 0);
    chk("m1_pixel", int'(bus.mons_pixel), 1);
    chk("m1_idx", int'(bus.hit_idx), 1);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 9);
    chk("repeat_kill_count", int'(bus.kill_count), 1);
    chk("repeat_alive", int'(bus.alive), 27);
    step(0, 0, 460, 100, 0, 0);
    chk("dead_m2_pixel", int'(bus.mons_pixel), 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (64) step(0, 1, 0, 0, 0, 0);
`ifdef MONS_DESCEND_EN
    ex = 374; ey = 110;
`else
    ex = 372; ey = 100;
`endif
    chk("edge_model_x", m_x, ex);
    chk("edge_model_y", m_y, ey);
    step(0, 0, ex, ey, 0, 0);
    chk("edge_pixel", int'(bus.mons_pixel), 1);
    chk("edge_idx", int'(bus.hit_idx), 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 250, 100, 0, 0);
    chk("reset_restores_x", int'(bus.mons_pixel), 1);
    for (int k = 0; k < N; k++) step(0, 0, 0, 0, 1, k);
    chk("all_killed_alive", int'(bus.alive), 0);
    chk("all_dead_early", int'(bus.all_dead), 0);
    step(0, 1, 0, 0, 0, 0);
    chk("all_dead_late", int'(bus.all_dead), 1);
    repeat (10) step(0, 1, 0, 0, 0, 0);
    chk("halt_model_x", m_x, 250);
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20000; c++) begin
      mi = $urandom_range(N - 1, 0);
      h = m_x + mi * SP + int'($urandom_range(14, 0)) - 7;
      v = m_y + int'($urandom_range(8, 0)) - 4;
      if ($urandom_range(7, 0) == 0) begin
        h = $urandom_range(1023, 0);
        v = $urandom_range(1023, 0);
      end
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      r = ($urandom_range(3999, 0) == 0) || (m_halt && $urandom_range(99, 0) == 0);
      step(r, $urandom_range(1, 0) == 1, h, v, $urandom_range(299, 0) == 0, $urandom_range(15, 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
